rca_slice_sequencer: RTL and testbench
======================================

Name: rca_slice_sequencer

Overview:
- Multi-cycle 32-bit adder controller. Time-shares one 8-bit ripple-carry slice (existing rca_8bit) between two requesters.
- Arbitrates round-robin between the two request ports and sequences the operands through the slice one byte per cycle, LSB first, chaining the carry in a register.
- Returns sum, carry-out and requester ID on a valid/ready response port.
- Used where area matters more than throughput; a drop-in for rca_32bit behind a handshake.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of SLICE.
- SLICE, 8, slice width; fixed to match rca_8bit.
- NSLICE, WIDTH/SLICE (4), derived localparam: passes per add.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  (same as req0)  requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  WIDTH  A+B+Cin mod 2^WIDTH.
- rsp_cout  out  1  carry out of MSB.
- rsp_id  out  1  requester that issued the result (0/1).

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, slice counter=0, carry reg=0, last_grant=1 (so req0 wins first tie).
- FSM states:
  - IDLE → BUSY on an accepted request.
  - BUSY → BUSY while cnt < NSLICE-1.
  - BUSY → DONE when cnt == NSLICE-1.
  - DONE → IDLE on rsp_valid & rsp_ready.
- Arbitration, IDLE only:
  - Grant reqN if only reqN_valid.
  - If both valid, grant the one that is not last_grant.
  - reqN_ready = (state==IDLE) & grantN. It is combinational from both valids; requesters must not make valid depend on ready.
  - At most one ready is high per cycle. Both readys are 0 outside IDLE.
- Acceptance edge:
  - Latch A, B and the granted ID; carry reg ← cin; cnt ← 0; last_grant ← granted ID.
- BUSY cycle k (k = cnt):
  - Slice inputs are A[k*8+:8], B[k*8+:8] and carry reg.
  - At the edge, sum reg[k*8+:8] ← slice sum, carry reg ← slice cout, cnt ← cnt+1.
- Latency and throughput:
  - Exactly NSLICE BUSY cycles. rsp_valid rises on the 4th edge after the acceptance edge.
  - rsp_cout = final carry reg.
  - Minimum initiation interval is NSLICE+2 cycles (accept, 4×BUSY, DONE handshake, IDLE).
  - No new acceptance is allowed in the same cycle as a response handshake.
- DONE:
  - rsp_valid, rsp_sum, rsp_cout and rsp_id are held stable until rsp_ready.
  - rsp_valid falls the cycle after the handshake.
  - Unbounded rsp_ready=0 stalls the block. Requests wait; nothing is dropped or overwritten.
- Request changes while not ready: operands are sampled only on the acceptance edge; later changes to req*_a/b/cin have no effect.
- Width rule: the sum is modulo 2^WIDTH; the carry propagates between slices only through the carry register, never combinationally across passes.
- Reset mid-operation (BUSY or DONE): in-flight result discarded, all outputs return to reset values the next cycle, no response is emitted.
- A request held valid across reset is re-arbitrated from IDLE with last_grant=1.

Decomposition:
- Package rca_seq_pkg holds:
  - state encoding (IDLE, BUSY, DONE) as a 2-bit enum;
  - WIDTH, SLICE and NSLICE constants;
  - the counter width, $clog2(NSLICE).
- Sub-module: instantiate rca_8bit once as the slice datapath. The arbiter and FSM are in this module.
- Optional small sub-module rr_arb2 for the 2-way round-robin grant; reusable elsewhere.

Test Plan:
- req0: A=0x12345678, B=0x87654321, cin=0 → rsp_sum=0x99999999, rsp_cout=0, rsp_id=0, rsp_valid exactly 4 edges after acceptance.
- req1: A=0xFFFFFFFF, B=0x00000001, cin=0 → rsp_sum=0x00000000, rsp_cout=1, rsp_id=1. Checks carry chaining through all 4 passes.
- req0: A=0xA5A5A5A5, B=0x5A5A5A5A, cin=1 → rsp_sum=0x00000000, rsp_cout=1.
- req0 and req1 both valid from reset → req0 served first, then req1. Both held valid continuously → grants alternate 0,1,0,1; no starvation.
- rsp_ready held 0 for 3 cycles in DONE with req1_valid=1 → rsp outputs stable, req1_ready=0 throughout. req1 is accepted only after the handshake and the return to IDLE.
- Assert rst_n=0 on the 2nd BUSY cycle → next cycle rsp_valid=0 and the state is IDLE. No response for the aborted op; the next request computes correctly (carry reg cleared).

Source files
------------

// File: rtl/rca_seq_pkg.sv
// Shared constants and state encoding for the time-shared 32-bit adder sequencer.
package rca_seq_pkg;

  localparam int RCA_WIDTH  = 32;
  localparam int RCA_SLICE  = 8;
  localparam int RCA_NSLICE = RCA_WIDTH / RCA_SLICE;
  localparam int RCA_CNT_W  = $clog2(RCA_NSLICE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rca_8bit.sv
// 8-bit ripple-carry adder slice; the combinational datapath shared by every pass.
module rca_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  always_comb begin
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time is granted.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = valid0 & (~valid1 | last_grant);
    grant1 = valid1 & (~valid0 | ~last_grant);
  end

endmodule

// File: rtl/rca_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder: two round-robin requesters share one 8-bit ripple slice,
// operands pass LSB byte first with the inter-slice carry held in a register.
module rca_slice_sequencer
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH,
  parameter int SLICE = RCA_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_q, last_d;

  logic             grant0, grant1;
  logic             accept;
  logic [SLICE-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_q),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  always_comb begin
    slice_a = a_q[int'(cnt_q) * SLICE +: SLICE];
    slice_b = b_q[int'(cnt_q) * SLICE +: SLICE];
  end

  rca_8bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)            state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: if (rsp_ready)         state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Readys only in IDLE, so a response handshake can never coincide with an acceptance.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
      end
      ST_DONE: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = req0_ready | req1_ready;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    last_d  = last_q;
    if (accept) begin
      a_d     = req1_ready ? req1_a   : req0_a;
      b_d     = req1_ready ? req1_b   : req0_b;
      carry_d = req1_ready ? req1_cin : req0_cin;
      cnt_d   = '0;
      id_d    = req1_ready;
      last_d  = req1_ready;
    end else if (state_q == ST_BUSY) begin
      sum_d[int'(cnt_q) * SLICE +: SLICE] = slice_sum;
      carry_d = slice_cout;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Operand holding registers are only meaningful after an acceptance, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign rsp_sum  = sum_q;
  assign rsp_cout = carry_q;
  assign rsp_id   = id_q;

endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Scoreboard bench for rca_slice_sequencer: a negedge monitor predicts readys, response
// timing and results from plain arithmetic and round-robin bookkeeping.
module tb_rca_slice_sequencer;

  localparam int W = 32;

  bit           clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [W-1:0] rsp_sum;

  rca_slice_sequencer #(.WIDTH(W), .SLICE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at cycle %0d: bound expired", name, cyc);
  endtask

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
  } exp_t;

  exp_t sb[$];
  bit   m_busy     = 1'b0;
  bit   m_last     = 1'b1;
  bit   m_rst_prev = 1'b0;
  int   m_acc      = 0;
  int   n_acc      = 0;
  int   n_rsp      = 0;
  int   n_abort    = 0;

  // Reference: idle unless an op is in flight; ties go to the requester that lost last time;
  // the result is ordinary 33-bit addition, ready exactly four edges after acceptance.
  always @(negedge clk) begin
    if (cyc > 0) begin
      bit er0, er1, ev;
      logic [W:0] t;
      exp_t e;
      er0 = !m_busy && req0_valid && (!req1_valid || m_last);
      er1 = !m_busy && req1_valid && (!req0_valid || !m_last);
      chk("req0_ready", req0_ready, er0);
      chk("req1_ready", req1_ready, er1);
      ev = m_busy && (cyc >= m_acc + 4);
      chk("rsp_valid", rsp_valid, ev);
      if (m_rst_prev) begin
        chk("reset_sum", rsp_sum, 0);
        chk("reset_cout", rsp_cout, 0);
        chk("reset_id", rsp_id, 0);
      end
      if (ev && rsp_valid && sb.size() > 0) begin
        chk("rsp_sum", rsp_sum, sb[0].sum);
        chk("rsp_cout", rsp_cout, sb[0].cout);
        chk("rsp_id", rsp_id, sb[0].id);
      end
      if (!rst_n) begin
        if (sb.size() > 0) n_abort++;
        sb.delete();
        m_busy     = 1'b0;
        m_last     = 1'b1;
        m_rst_prev = 1'b1;
      end else begin
        m_rst_prev = 1'b0;
        if (ev && rsp_valid && rsp_ready) begin
          if (sb.size() > 0) void'(sb.pop_front());
          m_busy = 1'b0;
          n_rsp++;
        end else if (er0 || er1) begin
          if (er1) t = {1'b0, req1_a} + {1'b0, req1_b} + {{W{1'b0}}, req1_cin};
          else     t = {1'b0, req0_a} + {1'b0, req0_b} + {{W{1'b0}}, req0_cin};
          e.sum  = t[W-1:0];
          e.cout = t[W];
          e.id   = er1;
          sb.push_back(e);
          m_busy = 1'b1;
          m_last = er1;
          m_acc  = cyc + 1;
          n_acc++;
        end
      end
    end
  end

  int rr_mode = 0;
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 3) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic drive(input int p, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    if (p == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_cin = c;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_cin = c;
    end
  endtask

  task automatic send(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int t;
    @(posedge clk);
    #1;
    drive(p, 1'b1, a, b, c);
    t = 0;
    forever begin
      @(negedge clk);
      if (rst_n && ((p == 0) ? req0_ready : req1_ready)) break;
      t++;
      if (t > 400) begin
        fail_now(p == 0 ? "send0_timeout" : "send1_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    // Scramble operands right after acceptance; only the sampled values may matter.
    drive(p, 1'b0, $urandom, $urandom, 1'($urandom));
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    while (m_busy || req0_valid || req1_valid) begin
      @(negedge clk);
      t++;
      if (t > 200) begin
        fail_now("drain_timeout");
        break;
      end
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(0, 32'h12345678, 32'h87654321, 1'b0);
    send(1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    send(0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1);
    wait_idle();

    // Both requesters valid across a reset, then kept busy back to back.
    @(posedge clk);
    #1 rst_n = 1'b0;
    fork
      begin repeat (2) @(posedge clk); #1 rst_n = 1'b1; end
      for (int i = 0; i < 3; i++) send(0, $urandom, $urandom, 1'($urandom));
      for (int j = 0; j < 3; j++) send(1, $urandom, $urandom, 1'($urandom));
    join
    wait_idle();

    // Consumer stalls in DONE while requester 1 waits.
    rr_mode = 2;
    fork
      send(0, 32'hFFFF00FF, 32'h0000FF01, 1'b0);
      begin
        int t;
        t = 0;
        while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) fail_now("stall_wait_valid");
        repeat (3) @(posedge clk);
        rr_mode = 0;
      end
      begin repeat (3) @(posedge clk); send(1, 32'h80000000, 32'h80000000, 1'b1); end
    join
    wait_idle();

    // Reset during the second BUSY cycle, then a fresh add.
    send(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    wait_idle();

    rr_mode = 1;
    fork
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        send(0, rand_op(), rand_op(), 1'($urandom));
      end
      for (int j = 0; j < 12; j++) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        send(1, rand_op(), rand_op(), 1'($urandom));
      end
    join
    rr_mode = 0;
    wait_idle();

    chk("scoreboard_empty", sb.size(), 0);
    chk("response_count", n_rsp, n_acc - n_abort);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
